// File: rtl/uart_axis_pkg.sv
// Shared constants, types and helpers for the UART-to-AXI-stream hex parser.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_axis_pkg;

    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_TAB   = 8'h09;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_A_UC  = 8'h41;
    localparam logic [7:0] ASC_A_LC  = 8'h61;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    typedef struct packed {
        logic       vld;
        logic [3:0] nib;
    } hex_t;

    // Map an ASCII character to its hex nibble; vld=0 for non-hex characters.
    function automatic hex_t ascii2hex(input logic [7:0] c);
        hex_t h;
        h.vld = 1'b0;
        h.nib = 4'h0;
        if (c >= ASC_0 && c <= ASC_0 + 8'd9) begin
            h.vld = 1'b1;
            h.nib = 4'(c - ASC_0);
        end else if (c >= ASC_A_UC && c <= ASC_A_UC + 8'd5) begin
            h.vld = 1'b1;
            h.nib = 4'(c - ASC_A_UC + 8'd10);
        end else if (c >= ASC_A_LC && c <= ASC_A_LC + 8'd5) begin
            h.vld = 1'b1;
            h.nib = 4'(c - ASC_A_LC + 8'd10);
        end
        return h;
    endfunction

    function automatic logic is_sep(input logic [7:0] c);
        return (c == ASC_SPACE) || (c == ASC_TAB);
    endfunction

    function automatic logic is_eol(input logic [7:0] c);
        return (c == ASC_LF) || (c == ASC_CR);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with 2-flop input synchronizer, mid-bit sampling.
// Latency: byte_valid/frame_err pulse in the stop-bit sample cycle (2-cycle sync lag).
// Backpressure: none; the serial line cannot be stalled, every pulse lasts one cycle.
module uart_rx_byte
    import uart_axis_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       uart_rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int                CNT_W   = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLK_DIV - 1);

    logic             sync1_q;
    logic             rx_s_q;
    logic             rx_prev_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tick;

    // Synchronizer and edge-detect history; idle-high line resets to 1.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= uart_rx;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // State register and bit-timing datapath.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

    // Next state: half a bit into START checks for a real start bit, then whole bits.
    always_comb begin
        tick      = (state_q == START) ? (cnt_q == HALF_M1) : (cnt_q == FULL_M1);
        state_d   = state_q;
        cnt_d     = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (rx_prev_q && !rx_s_q) state_d = START;
            end
            START: begin
                if (tick) state_d = rx_s_q ? IDLE : DATA;
            end
            DATA: begin
                if (tick) begin
                    shreg_d   = {rx_s_q, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: result of the stop-bit sample, valid for exactly that cycle.
    always_comb begin
        byte_valid = (state_q == STOP) && tick && rx_s_q;
        frame_err  = (state_q == STOP) && tick && !rx_s_q;
        byte_data  = shreg_q;
    end

endmodule

// File: rtl/uart_rx_to_axi_stream.sv
// UART hex-text receiver: parses ASCII hex words into AXI-stream beats via a FIFO.
// Latency: terminator byte_valid to tvalid is 2 cycles with the FIFO empty.
// Backpressure: FIFO absorbs tready stalls; a word arriving to a full FIFO is dropped (drop pulse).
module uart_rx_to_axi_stream
    import uart_axis_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_ASIZE = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  uart_rx,
    output logic                  tvalid,
    input  logic                  tready,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  tlast,
    output logic                  drop
);

    localparam int DEPTH = 1 << FIFO_ASIZE;

    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  frame_err;
    hex_t                  hex;

    logic [DATA_WIDTH-1:0] accum_q, accum_d;
    logic                  ndig_q, ndig_d;
    logic                  bad_q, bad_d;
    logic                  push_vld_q, push_vld_d;
    logic [DATA_WIDTH:0]   push_dat_q, push_dat_d;

    logic [FIFO_ASIZE-1:0] wpt_q, wpt_d, rpt_q, rpt_d, wpt_inc;
    logic [DATA_WIDTH:0]   head_q, head_d;
    logic                  full, wr_en, pop;
    logic [DATA_WIDTH:0]   ram [DEPTH];

    uart_rx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_rx (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .uart_rx    (uart_rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    // Token parser: accumulate hex digits, emit {eol, word} on a terminator if the token is clean.
    always_comb begin
        hex        = ascii2hex(byte_data);
        accum_d    = accum_q;
        ndig_d     = ndig_q;
        bad_d      = bad_q;
        push_vld_d = 1'b0;
        push_dat_d = push_dat_q;
        if (frame_err) begin
            bad_d = 1'b1;
        end else if (byte_valid) begin
            if (hex.vld) begin
                accum_d = {accum_q[DATA_WIDTH-5:0], hex.nib};
                ndig_d  = 1'b1;
            end else if (is_sep(byte_data) || is_eol(byte_data)) begin
                push_vld_d = ndig_q & ~bad_q;
                push_dat_d = {is_eol(byte_data), accum_q};
                accum_d    = '0;
                ndig_d     = 1'b0;
                bad_d      = 1'b0;
            end else begin
                bad_d = 1'b1;
            end
        end
    end

    // FIFO control; full is judged before this cycle's pop. The head register is
    // refilled on pop, or bypassed from the write port when the write lands at the head.
    always_comb begin
        wpt_inc = wpt_q + 1'b1;
        full    = (wpt_inc == rpt_q);
        wr_en   = push_vld_q & ~full;
        pop     = tvalid & tready;
        wpt_d   = wr_en ? wpt_inc : wpt_q;
        rpt_d   = pop ? rpt_q + 1'b1 : rpt_q;
        head_d  = head_q;
        if (wr_en && (wpt_q == rpt_d)) begin
            head_d = push_dat_q;
        end else if (pop) begin
            head_d = ram[rpt_d];
        end
    end

    // Parser, push stage, pointers and show-ahead head register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            accum_q    <= '0;
            ndig_q     <= 1'b0;
            bad_q      <= 1'b0;
            push_vld_q <= 1'b0;
            push_dat_q <= '0;
            wpt_q      <= '0;
            rpt_q      <= '0;
            head_q     <= '0;
        end else begin
            accum_q    <= accum_d;
            ndig_q     <= ndig_d;
            bad_q      <= bad_d;
            push_vld_q <= push_vld_d;
            push_dat_q <= push_dat_d;
            wpt_q      <= wpt_d;
            rpt_q      <= rpt_d;
            head_q     <= head_d;
        end
    end

    // Word storage: simple dual-port RAM, written only into free slots.
    always_ff @(posedge aclk) begin
        if (wr_en) ram[wpt_q] <= push_dat_q;
    end

    assign tvalid = (rpt_q != wpt_q);
    assign tdata  = head_q[DATA_WIDTH-1:0];
    assign tlast  = head_q[DATA_WIDTH];
    assign drop   = push_vld_q & full;

endmodule

// File: tb/tb_uart_rx_to_axi_stream.sv
// Self-checking bench: UART hex text in, AXI-stream beats compared against a token-level model.
// Latency: n/a (testbench).
// Backpressure: tready forced low, high, or randomised per phase.
module tb_uart_rx_to_axi_stream;

    localparam int CLK_DIV = 8;
    localparam int DW      = 32;
    localparam int ASZ     = 2;
    localparam int DEPTH   = (1 << ASZ) - 1;

    logic          aclk    = 1'b0;
    logic          aresetn = 1'b0;
    logic          uart_rx = 1'b1;
    logic          tready;
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          drop;

    always #5 aclk = ~aclk;

    uart_rx_to_axi_stream #(
        .CLK_DIV    (CLK_DIV),
        .DATA_WIDTH (DW),
        .FIFO_ASIZE (ASZ)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .uart_rx (uart_rx),
        .tvalid  (tvalid),
        .tready  (tready),
        .tdata   (tdata),
        .tlast   (tlast),
        .drop    (drop)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (token level) ----------------
    logic [DW:0] exp_q[$];
    int          digs[$];
    bit          tok_bad    = 1'b0;
    bit          stall_mode = 1'b0;
    int          stalled    = 0;
    int          exp_drops  = 0;
    int          drop_cnt   = 0;

    function automatic int hexval(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    // While downstream is stalled only DEPTH words fit; later ones are lost.
    task automatic model_push(input logic [DW-1:0] v, input bit last);
        if (stall_mode && stalled >= DEPTH) begin
            exp_drops++;
        end else begin
            exp_q.push_back({last, v});
            if (stall_mode) stalled++;
        end
    endtask

    task automatic model_char(input logic [7:0] c, input bit corrupt);
        longint v;
        if (corrupt) begin
            tok_bad = 1'b1;
        end else if (c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D) begin
            if (digs.size() > 0 && !tok_bad) begin
                v = 0;
                foreach (digs[i]) v = (v * 16 + longint'(digs[i])) % (longint'(1) << DW);
                model_push(v[DW-1:0], (c == 8'h0A || c == 8'h0D));
            end
            digs.delete();
            tok_bad = 1'b0;
        end else if (hexval(c) >= 0) begin
            digs.push_back(hexval(c));
        end else begin
            tok_bad = 1'b1;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic uart_send(input logic [7:0] c, input bit stop_bit);
        uart_rx = 1'b0;
        cyc(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = c[i];
            cyc(CLK_DIV);
        end
        uart_rx = stop_bit;
        cyc(CLK_DIV);
        uart_rx = 1'b1;
        if (!stop_bit) cyc(CLK_DIV);
    endtask

    task automatic send_char(input logic [7:0] c, input bit corrupt);
        model_char(c, corrupt);
        uart_send(c, !corrupt);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b0);
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_tvalid"}, 64'(tvalid), 64'(0));
        chk({tag, "_drop"},   64'(drop),   64'(0));
        chk({tag, "_tdata"},  64'(tdata),  64'(0));
        chk({tag, "_tlast"},  64'(tlast),  64'(0));
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tvalid) && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        chk({tag, "_left"}, 64'(exp_q.size()), 64'(0));
        cyc(20);
    endtask

    // ---------------- tready driver ----------------
    bit rand_rdy  = 1'b0;
    bit rdy_force = 1'b1;

    initial begin
        tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            tready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    // ---------------- output monitor / scoreboard ----------------
    logic [DW:0] held;
    logic [DW:0] e_m;
    bit          prev_stall = 1'b0;

    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && tvalid) chk("hold", 64'({tlast, tdata}), 64'(held));
            if (drop) drop_cnt++;
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat_tvalid", 64'(tvalid), 64'(0));
                end else begin
                    e_m = exp_q.pop_front();
                    chk("tdata", 64'(tdata), 64'(e_m[DW-1:0]));
                    chk("tlast", 64'(tlast), 64'(e_m[DW]));
                end
            end
            prev_stall = tvalid && !tready;
            held       = {tlast, tdata};
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        string hexch;
        string seps;
        int    d0;
        int    e0;
        int    nd;
        int    n;
        hexch = "0123456789abcdefABCDEF";
        seps  = " \t\n\r";

        cyc(5);
        reset_chk("rst");
        aresetn = 1'b1;
        cyc(5);

        // Single word with end-of-line; check terminator-to-tvalid latency while stalled.
        rdy_force = 1'b0;
        cyc(2);
        send_str("1A2B3C4D");
        send_char(8'h0A, 1'b0);
        n = 0;
        @(negedge aclk);
        while (!tvalid && n < 1) begin
            @(negedge aclk);
            n++;
        end
        chk("latency_tvalid", 64'(tvalid), 64'(1));
        rdy_force = 1'b1;
        wait_drain("t1");

        // Separator then CRLF: two beats, LF adds nothing.
        send_str("12 ab\r\n");
        wait_drain("t2");

        // Truncation of a long word, then a bad token followed by a good one.
        send_str("123456789\n");
        wait_drain("t3a");
        send_str("12G4 5\n");
        wait_drain("t3b");

        // FIFO full while stalled: three stored, fourth dropped.
        rdy_force  = 1'b0;
        stall_mode = 1'b1;
        stalled    = 0;
        d0         = drop_cnt;
        e0         = exp_drops;
        cyc(2);
        send_str("1 2 3 4 ");
        cyc(10);
        chk("stall_tvalid", 64'(tvalid), 64'(1));
        chk("stall_drops", 64'(drop_cnt - d0), 64'(exp_drops - e0));
        stall_mode = 1'b0;
        rdy_force  = 1'b1;
        wait_drain("t4");
        chk("t4_tvalid_idle", 64'(tvalid), 64'(0));

        // Short glitch on the line must not start a frame.
        uart_rx = 1'b0;
        cyc(2);
        uart_rx = 1'b1;
        cyc(12 * CLK_DIV);
        chk("glitch_tvalid", 64'(tvalid), 64'(0));
        // Framing errors poison the current token.
        send_char("5", 1'b0);
        send_char("?", 1'b1);
        send_char(8'h0A, 1'b0);
        send_char("6", 1'b0);
        send_char("7", 1'b1);
        send_char(8'h0A, 1'b0);
        send_str("9\n");
        wait_drain("t5");

        // Reset in the middle of a frame with a beat pending and a partial token.
        rdy_force = 1'b0;
        cyc(2);
        send_str("3\n6");
        uart_rx = 1'b0;
        cyc(CLK_DIV);
        for (int i = 0; i < 3; i++) begin
            uart_rx = 1'b1;
            cyc(CLK_DIV);
        end
        chk("pre_rst_tvalid", 64'(tvalid), 64'(1));
        aresetn = 1'b0;
        cyc(2);
        reset_chk("midrst");
        exp_q.delete();
        digs.delete();
        tok_bad   = 1'b0;
        uart_rx   = 1'b1;
        rdy_force = 1'b1;
        cyc(3);
        aresetn = 1'b1;
        cyc(5);
        send_str("8\n");
        wait_drain("t6");

        // Randomised tokens with random backpressure, bad characters and framing errors.
        rand_rdy = 1'b1;
        for (int t = 0; t < 25; t++) begin
            nd = $urandom_range(1, 10);
            for (int k = 0; k < nd; k++) begin
                if ($urandom_range(0, 24) == 0)
                    send_char("g", 1'b0);
                else
                    send_char(hexch[$urandom_range(0, 21)], ($urandom_range(0, 39) == 0));
            end
            send_char(seps[$urandom_range(0, 3)], 1'b0);
        end
        send_char(8'h0A, 1'b0);
        wait_drain("rand");
        rand_rdy = 1'b0;
        cyc(5);

        chk("total_drops", 64'(drop_cnt), 64'(exp_drops));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
